// File: rtl/memmu_point_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : memmu_point_writer_if
//  Description : Single-beat AXI4 write channel bundle (AW, W and B) between
//                the point writer (master) and point-cloud memory (slave).
//  Signals     : awaddr/awvalid/awready    write address channel
//                wdata/wstrb/wlast/wvalid/wready  write data channel
//                bresp/bvalid/bready       write response channel
//  Revision    : 1.0 - initial release
// ============================================================================
interface memmu_point_writer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface
`default_nettype wire

// File: rtl/memmu_point_writer.sv
`default_nettype none
// ============================================================================
//  Module      : memmu_point_writer
//  Description : Buffers MemMU point writes (address + payload) in a FIFO and
//                drains them as single-beat AXI4 writes to point-cloud memory.
//                Counts completed writes per frame and pulses o_frameDone once
//                every write of the previous frame has been acknowledged.
//  Ports       : i_SYSTEM_clk / i_SYSTEM_rst   clock, async active-low reset
//                i_MemMU_*  / o_MemMU_ready    point write request handshake
//                i_SIU_newFrame                one-cycle new-frame pulse
//                m_axi                         AXI4 write master (AW, W, B)
//                o_writeCount                  writes done in current frame
//                o_lastFrameCount              writes done in previous frame
//                o_frameDone                   previous frame fully in memory
//                o_status                      [0] busy [1] full [2] bresp err
//                                              [3] overflow [4] frame pending
//                                              [15:8] fill level
//  Revision    : 1.0 - initial release
// ============================================================================
module memmu_point_writer #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  wire logic                  i_SYSTEM_clk,
    input  wire logic                  i_SYSTEM_rst,
    input  wire logic                  i_MemMU_valid,
    output logic                       o_MemMU_ready,
    input  wire logic [ADDR_WIDTH-1:0] i_MemMU_pointWriteAddress,
    input  wire logic [DATA_WIDTH-1:0] i_MemMU_pointWritePayload,
    input  wire logic                  i_SIU_newFrame,
    memmu_point_writer_if.master       m_axi,
    output logic [18:0]                o_writeCount,
    output logic [18:0]                o_lastFrameCount,
    output logic                       o_frameDone,
    output logic [31:0]                o_status
);

    localparam int c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

    localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(FIFO_DEPTH);
    localparam logic [18:0]        c_COUNT_MAX = 19'h7FFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [c_ENTRY_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_CNT_W-1:0]    w_count_next;
    logic                  r_ready;
    logic                  r_overflow;
    logic                  r_pending;
    logic                  w_pending_next;
    logic                  w_frame_done;
    logic                  r_frame_done;
    logic [18:0]           r_write_count;
    logic [18:0]           r_last_frame_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_busy;
    logic [c_ENTRY_W-1:0]  w_head;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [8:0]            w_fill9;
    logic [7:0]            w_fill8;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_awvalid;
    logic                  w_awvalid_next;
    logic                  r_wvalid;
    logic                  w_wvalid_next;
    logic                  r_bready;
    logic                  w_bready_next;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [ADDR_WIDTH-1:0] w_awaddr_next;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] w_wdata_next;
    logic                  r_bresp_err;
    logic                  w_bresp_err_next;
    logic                  w_b_accept;
    logic                  w_aw_done;
    logic                  w_w_done;

    // ------------------------------------------------------------------------
    // Write buffer
    // ------------------------------------------------------------------------
    // Ready is a register, so a request seen while ready is low is lost and
    // only flagged; the requester is expected to honour ready.
    assign w_push = i_MemMU_valid && r_ready;
    assign w_full = (r_count == c_FULL);
    assign w_head = r_mem[r_rd_ptr];
    assign w_head_addr = w_head[c_ENTRY_W-1:DATA_WIDTH];
    assign w_head_data = w_head[DATA_WIDTH-1:0];

    always_ff @(posedge i_SYSTEM_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_MemMU_pointWriteAddress, i_MemMU_pointWritePayload};
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_CNT_W'(1);
        end
    end

    // A frame closes only once the buffer is empty and the last response has
    // been taken, so everything counted is guaranteed to be in memory.
    assign w_frame_done = r_pending && (r_count == '0) && (r_state == S_IDLE);

    always_comb begin
        w_pending_next = r_pending;
        if (w_frame_done) begin
            w_pending_next = 1'b0;
        end else if (i_SIU_newFrame) begin
            w_pending_next = 1'b1;
        end
    end

    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            r_wr_ptr           <= '0;
            r_rd_ptr           <= '0;
            r_count            <= '0;
            r_ready            <= 1'b0;
            r_overflow         <= 1'b0;
            r_pending          <= 1'b0;
            r_frame_done       <= 1'b0;
            r_write_count      <= '0;
            r_last_frame_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count   <= w_count_next;
            r_pending <= w_pending_next;
            // Looking at the next-cycle fill and pending state keeps ready
            // exact without a combinational path from the request.
            r_ready   <= (w_count_next != c_FULL) && !w_pending_next;
            if (i_MemMU_valid && !r_ready) begin
                r_overflow <= 1'b1;
            end
            r_frame_done <= w_frame_done;
            if (w_frame_done) begin
                r_last_frame_count <= r_write_count;
                r_write_count      <= '0;
            end else if (w_b_accept && (r_write_count != c_COUNT_MAX)) begin
                r_write_count <= r_write_count + 19'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // AXI write FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            r_state     <= S_IDLE;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_bresp_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_awvalid   <= w_awvalid_next;
            r_wvalid    <= w_wvalid_next;
            r_bready    <= w_bready_next;
            r_awaddr    <= w_awaddr_next;
            r_wdata     <= w_wdata_next;
            r_bresp_err <= w_bresp_err_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_awvalid_next   = r_awvalid;
        w_wvalid_next    = r_wvalid;
        w_bready_next    = r_bready;
        w_awaddr_next    = r_awaddr;
        w_wdata_next     = r_wdata;
        w_bresp_err_next = r_bresp_err;
        w_pop            = 1'b0;
        w_b_accept       = 1'b0;
        w_aw_done        = 1'b0;
        w_w_done         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop          = 1'b1;
                    w_awaddr_next  = w_head_addr;
                    w_wdata_next   = w_head_data;
                    w_awvalid_next = 1'b1;
                    w_wvalid_next  = 1'b1;
                    w_state_next   = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // A channel counts as done if it handshook earlier (valid
                // already dropped) or is handshaking in this cycle.
                w_aw_done = !r_awvalid || m_axi.awready;
                w_w_done  = !r_wvalid  || m_axi.wready;
                if (r_awvalid && m_axi.awready) begin
                    w_awvalid_next = 1'b0;
                end
                if (r_wvalid && m_axi.wready) begin
                    w_wvalid_next = 1'b0;
                end
                if (w_aw_done && w_w_done) begin
                    w_bready_next = 1'b1;
                    w_state_next  = S_RESP;
                end
            end

            S_RESP: begin
                if (m_axi.bvalid) begin
                    w_bready_next = 1'b0;
                    w_b_accept    = 1'b1;
                    if (m_axi.bresp != 2'b00) begin
                        w_bresp_err_next = 1'b1;
                    end
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign m_axi.awaddr  = r_awaddr;
    assign m_axi.awvalid = r_awvalid;
    assign m_axi.wdata   = r_wdata;
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = 1'b1;
    assign m_axi.wvalid  = r_wvalid;
    assign m_axi.bready  = r_bready;

    assign o_MemMU_ready    = r_ready;
    assign o_writeCount     = r_write_count;
    assign o_lastFrameCount = r_last_frame_count;
    assign o_frameDone      = r_frame_done;

    // Fill level field is 8 bits wide; a 256-deep buffer reports 255 when full.
    assign w_busy  = (r_state != S_IDLE) || (r_count != '0);
    assign w_fill9 = 9'(r_count);
    assign w_fill8 = w_fill9[8] ? 8'hFF : w_fill9[7:0];

    assign o_status = {16'd0, w_fill8, 3'd0, r_pending, r_overflow,
                       r_bresp_err, w_full, w_busy};

endmodule
`default_nettype wire

// File: tb/tb_memmu_point_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memmu_point_writer
//  Description : Self-checking bench for memmu_point_writer. An AXI slave
//                responder with programmable delays records every accepted
//                address and data beat; a queue of accepted points is the
//                reference for ordering, and frame counts follow from it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memmu_point_writer;

    localparam int FIFO_DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [31:0] mem_addr = '0;
    logic [63:0] mem_data = '0;
    logic        new_frame = 1'b0;
    logic [18:0] write_count;
    logic [18:0] last_frame_count;
    logic        frame_done;
    logic [31:0] status;

    memmu_point_writer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) axi ();

    memmu_point_writer #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .ADDR_WIDTH(32),
        .DATA_WIDTH(64)
    ) dut (
        .i_SYSTEM_clk              (clk),
        .i_SYSTEM_rst              (rst_n),
        .i_MemMU_valid             (mem_valid),
        .o_MemMU_ready             (mem_ready),
        .i_MemMU_pointWriteAddress (mem_addr),
        .i_MemMU_pointWritePayload (mem_data),
        .i_SIU_newFrame            (new_frame),
        .m_axi                     (axi),
        .o_writeCount              (write_count),
        .o_lastFrameCount          (last_frame_count),
        .o_frameDone               (frame_done),
        .o_status                  (status)
    );

    initial forever #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] exp_addr[$];
    logic [63:0] exp_data[$];
    int          exp_count = 0;

    // AXI slave configuration and observations
    bit          stall = 1'b0;
    int          aw_delay = 0;
    int          w_delay = 0;
    int          b_delay = 0;
    int          b_err_at = -1;
    int          b_count = 0;
    int          aw_wait = 0;
    int          w_wait = 0;
    int          b_wait = 0;
    int          aw_hi = 0;
    int          w_hi = 0;
    int          last_aw_hi = 0;
    int          last_w_hi = 0;
    logic [31:0] got_aw[$];
    logic [63:0] got_w[$];

    // AXI slave responder: acts on the falling edge, DUT samples on the rising
    initial begin
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                axi.awready = 1'b0;
                axi.wready  = 1'b0;
                axi.bvalid  = 1'b0;
                axi.bresp   = 2'b00;
                aw_wait = 0; w_wait = 0; b_wait = 0; aw_hi = 0; w_hi = 0;
            end else begin
                if (axi.awready) begin
                    axi.awready = 1'b0;
                end else if (axi.awvalid) begin
                    aw_hi++;
                    if (!stall && aw_wait >= aw_delay) begin
                        axi.awready = 1'b1;
                        got_aw.push_back(axi.awaddr);
                        last_aw_hi = aw_hi;
                        aw_hi = 0;
                        aw_wait = 0;
                    end else if (!stall) begin
                        aw_wait++;
                    end
                end
                if (axi.wready) begin
                    axi.wready = 1'b0;
                end else if (axi.wvalid) begin
                    w_hi++;
                    if (!stall && w_wait >= w_delay) begin
                        axi.wready = 1'b1;
                        got_w.push_back(axi.wdata);
                        last_w_hi = w_hi;
                        w_hi = 0;
                        w_wait = 0;
                    end else if (!stall) begin
                        w_wait++;
                    end
                end
                if (axi.bvalid) begin
                    axi.bvalid = 1'b0;
                    axi.bresp  = 2'b00;
                end else if (axi.bready && !stall) begin
                    if (b_wait >= b_delay) begin
                        axi.bvalid = 1'b1;
                        axi.bresp  = (b_count == b_err_at) ? 2'b10 : 2'b00;
                        b_count++;
                        b_wait = 0;
                    end else begin
                        b_wait++;
                    end
                end
            end
        end
    end

    task automatic clear_model();
        exp_addr.delete();
        exp_data.delete();
        got_aw.delete();
        got_w.delete();
        b_count = 0;
    endtask

    // Presents one point once ready is seen; called and returns on a falling edge
    task automatic push_point(input logic [31:0] a, input logic [63:0] d);
        int n = 0;
        while (mem_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (mem_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL push_wait_ready got=%b want=1", mem_ready);
        end else begin
            mem_valid = 1'b1;
            mem_addr  = a;
            mem_data  = d;
            exp_addr.push_back(a);
            exp_data.push_back(d);
            @(negedge clk);
            mem_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (status[0] !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (status[0] !== 1'b0) begin
            checks++; errors++;
            $display("FAIL drain_timeout busy=%b want=0", status[0]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_valid = 1'b0;
        new_frame = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_ready, axi.awvalid, axi.wvalid, axi.bready, frame_done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b want=00000",
                     {mem_ready, axi.awvalid, axi.wvalid, axi.bready, frame_done});
        end
        checks++;
        if (axi.wstrb !== 8'hFF || axi.wlast !== 1'b1) begin
            errors++;
            $display("FAIL reset_wstrb_wlast got=%h/%b want=ff/1", axi.wstrb, axi.wlast);
        end
        checks++;
        if (status !== 32'd0 || write_count !== 19'd0 || last_frame_count !== 19'd0) begin
            errors++;
            $display("FAIL reset_status got=%h/%0d/%0d want=0/0/0",
                     status, write_count, last_frame_count);
        end
        checks++;
        if (axi.awaddr !== 32'd0 || axi.wdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_bus got=%h/%h want=0/0", axi.awaddr, axi.wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b want=1", mem_ready);
        end
        exp_count = 0;
        clear_model();
    endtask

    task automatic test_basic();
        clear_model();
        aw_delay = 0; w_delay = 0; b_delay = 0;
        push_point(32'h100, 64'hA);
        push_point(32'h108, 64'hB);
        push_point(32'h110, 64'hC);
        wait_idle(500);
        exp_count += exp_addr.size();
        checks++;
        if (got_aw.size() != 3 || got_w.size() != 3) begin
            errors++;
            $display("FAIL basic_beats got=%0d/%0d want=3/3", got_aw.size(), got_w.size());
        end
        for (int i = 0; i < exp_addr.size() && i < got_aw.size() && i < got_w.size(); i++) begin
            checks++;
            if (got_aw[i] !== exp_addr[i] || got_w[i] !== exp_data[i]) begin
                errors++;
                $display("FAIL basic_order[%0d] got=%h/%h want=%h/%h",
                         i, got_aw[i], got_w[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (write_count !== 19'(exp_count)) begin
            errors++;
            $display("FAIL basic_count got=%0d want=%0d", write_count, exp_count);
        end
    endtask

    task automatic test_latency();
        clear_model();
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0A00;
        mem_data  = 64'h1122_3344_5566_7788;
        @(negedge clk);
        mem_valid = 1'b0;
        checks++;
        if (axi.awvalid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got=%b want=0", axi.awvalid);
        end
        @(negedge clk);
        checks++;
        if (axi.awvalid !== 1'b1 || axi.wvalid !== 1'b1 || axi.awaddr !== 32'h0000_0A00
            || axi.wdata !== 64'h1122_3344_5566_7788) begin
            errors++;
            $display("FAIL latency_issue got=%b%b %h %h want=11 00000a00 1122334455667788",
                     axi.awvalid, axi.wvalid, axi.awaddr, axi.wdata);
        end
        wait_idle(500);
        exp_count += 1;
        checks++;
        if (write_count !== 19'(exp_count)) begin
            errors++;
            $display("FAIL latency_count got=%0d want=%0d", write_count, exp_count);
        end
    endtask

    task automatic test_aw_delay();
        clear_model();
        aw_delay = 4; w_delay = 0; b_delay = 0;
        push_point(32'h0000_2220, 64'hDEAD_BEEF_0000_0001);
        wait_idle(500);
        exp_count += 1;
        checks++;
        if (last_aw_hi != aw_delay + 1 || last_w_hi != w_delay + 1) begin
            errors++;
            $display("FAIL awdelay_valid_cycles got=%0d/%0d want=%0d/%0d",
                     last_aw_hi, last_w_hi, aw_delay + 1, w_delay + 1);
        end
        checks++;
        if (b_count != 1 || write_count !== 19'(exp_count)) begin
            errors++;
            $display("FAIL awdelay_resp got=%0d/%0d want=1/%0d", b_count, write_count, exp_count);
        end
        aw_delay = 0;
    endtask

    task automatic test_overflow();
        int accepted = 0;
        int first_drop = -1;
        bit acc;
        clear_model();
        stall = 1'b1;
        // The head point leaves the buffer for the AXI stage, so the buffer
        // holds FIFO_DEPTH more before ready drops.
        for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
            acc = mem_ready;
            mem_valid = 1'b1;
            mem_addr  = 32'h0000_2000 + 32'(i * 8);
            mem_data  = {$urandom, $urandom};
            if (acc) begin
                accepted++;
                exp_addr.push_back(mem_addr);
                exp_data.push_back(mem_data);
            end else if (first_drop < 0) begin
                first_drop = i;
            end
            @(negedge clk);
        end
        mem_valid = 1'b0;
        checks++;
        if (accepted != FIFO_DEPTH + 1 || first_drop != FIFO_DEPTH + 1) begin
            errors++;
            $display("FAIL overflow_accepted got=%0d/%0d want=%0d/%0d",
                     accepted, first_drop, FIFO_DEPTH + 1, FIFO_DEPTH + 1);
        end
        checks++;
        if (mem_ready !== 1'b0 || status[3] !== 1'b1 || status[1] !== 1'b1
            || status[15:8] !== 8'(FIFO_DEPTH)) begin
            errors++;
            $display("FAIL overflow_status got=%b %h want=0 with ovf,full,fill=%0d",
                     mem_ready, status, FIFO_DEPTH);
        end
        stall = 1'b0;
        wait_idle(2000);
        exp_count += exp_addr.size();
        checks++;
        if (got_aw.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL overflow_beats got=%0d want=%0d", got_aw.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < got_aw.size() && i < got_w.size(); i++) begin
            checks++;
            if (got_aw[i] !== exp_addr[i] || got_w[i] !== exp_data[i]) begin
                errors++;
                $display("FAIL overflow_order[%0d] got=%h/%h want=%h/%h",
                         i, got_aw[i], got_w[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (write_count !== 19'(exp_count) || status[15:8] !== 8'd0) begin
            errors++;
            $display("FAIL overflow_count got=%0d fill=%0d want=%0d fill=0",
                     write_count, status[15:8], exp_count);
        end
    endtask

    task automatic test_frame();
        int  n = 0;
        bit  seen = 1'b0;
        bit  ready_leak = 1'b0;
        int  b_at_done = -1;
        logic ready_at_done = 1'b0;
        aw_delay = 0; w_delay = 0; b_delay = 0;
        // Empty frame: closes whatever is counted so far
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        checks++;
        if (status[4] !== 1'b1 || mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL frame_pending got=%b/%b want=1/0", status[4], mem_ready);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1 || last_frame_count !== 19'(exp_count) || write_count !== 19'd0) begin
            errors++;
            $display("FAIL frame_empty got=%b/%0d/%0d want=1/%0d/0",
                     frame_done, last_frame_count, write_count, exp_count);
        end
        exp_count = 0;
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL frame_pulse_width got=%b want=0", frame_done);
        end

        // Four queued points; the fourth shares its cycle with newFrame
        clear_model();
        b_delay = 3;
        for (int i = 0; i < 3; i++) begin
            push_point(32'h0003_0000 + 32'(i * 8), {32'hF00D, 32'(i)});
        end
        checks++;
        if (mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL frame_ready_before got=%b want=1", mem_ready);
        end
        mem_valid = 1'b1;
        mem_addr  = 32'h0003_0018;
        mem_data  = {32'hF00D, 32'd3};
        new_frame = 1'b1;
        exp_addr.push_back(mem_addr);
        exp_data.push_back(mem_data);
        @(negedge clk);
        mem_valid = 1'b0;
        new_frame = 1'b0;
        while (!seen && n < 1000) begin
            if (frame_done === 1'b1) begin
                seen = 1'b1;
                b_at_done = b_count;
                ready_at_done = mem_ready;
            end else begin
                if (mem_ready !== 1'b0) ready_leak = 1'b1;
                @(negedge clk);
                n++;
            end
        end
        checks++;
        if (!seen || ready_leak) begin
            errors++;
            $display("FAIL frame_done_seen got=%b leak=%b want=1 leak=0", seen, ready_leak);
        end
        checks++;
        if (b_at_done != exp_addr.size() || got_aw.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL frame_resp_before_done got=%0d/%0d want=%0d",
                     b_at_done, got_aw.size(), exp_addr.size());
        end
        checks++;
        if (last_frame_count !== 19'(exp_addr.size()) || write_count !== 19'd0
            || ready_at_done !== 1'b1) begin
            errors++;
            $display("FAIL frame_counts got=%0d/%0d/%b want=%0d/0/1",
                     last_frame_count, write_count, ready_at_done, exp_addr.size());
        end
        exp_count = 0;
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0 || status[4] !== 1'b0) begin
            errors++;
            $display("FAIL frame_after got=%b/%b want=0/0", frame_done, status[4]);
        end
        b_delay = 0;
    endtask

    task automatic test_bresp();
        clear_model();
        b_err_at = 1;
        push_point(32'h0004_0000, 64'h1);
        wait_idle(500);
        exp_count += 1;
        checks++;
        if (status[2] !== 1'b0) begin
            errors++;
            $display("FAIL bresp_first got=%b want=0", status[2]);
        end
        push_point(32'h0004_0008, 64'h2);
        wait_idle(500);
        exp_count += 1;
        checks++;
        if (status[2] !== 1'b1 || write_count !== 19'(exp_count)) begin
            errors++;
            $display("FAIL bresp_error got=%b/%0d want=1/%0d", status[2], write_count, exp_count);
        end
        push_point(32'h0004_0010, 64'h3);
        wait_idle(500);
        exp_count += 1;
        checks++;
        if (status[2] !== 1'b1) begin
            errors++;
            $display("FAIL bresp_sticky got=%b want=1", status[2]);
        end
        b_err_at = -1;
    endtask

    task automatic test_random();
        clear_model();
        for (int i = 0; i < 40; i++) begin
            aw_delay = $urandom_range(0, 3);
            w_delay  = $urandom_range(0, 3);
            b_delay  = $urandom_range(0, 2);
            push_point($urandom & 32'hFFFF_FFF8, {$urandom, $urandom});
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle(5000);
        exp_count += exp_addr.size();
        checks++;
        if (got_aw.size() != exp_addr.size() || got_w.size() != exp_data.size()) begin
            errors++;
            $display("FAIL random_beats got=%0d/%0d want=%0d",
                     got_aw.size(), got_w.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < got_aw.size() && i < got_w.size(); i++) begin
            checks++;
            if (got_aw[i] !== exp_addr[i] || got_w[i] !== exp_data[i]) begin
                errors++;
                $display("FAIL random_order[%0d] got=%h/%h want=%h/%h",
                         i, got_aw[i], got_w[i], exp_addr[i], exp_data[i]);
            end
        end
        checks++;
        if (write_count !== 19'(exp_count)) begin
            errors++;
            $display("FAIL random_count got=%0d want=%0d", write_count, exp_count);
        end
        aw_delay = 0; w_delay = 0; b_delay = 0;
    endtask

    task automatic test_reset_mid();
        clear_model();
        aw_delay = 50; w_delay = 50;
        push_point(32'h0005_0000, 64'h55);
        push_point(32'h0005_0008, 64'h66);
        push_point(32'h0005_0010, 64'h77);
        repeat (3) @(negedge clk);
        checks++;
        if (axi.awvalid !== 1'b1 || status[0] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_issue got=%b/%b want=1/1", axi.awvalid, status[0]);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_ready, axi.awvalid, axi.wvalid, axi.bready, frame_done} !== 5'b0
            || status !== 32'd0 || write_count !== 19'd0 || last_frame_count !== 19'd0
            || axi.awaddr !== 32'd0 || axi.wdata !== 64'd0) begin
            errors++;
            $display("FAIL midreset_async got=%b %h %0d %0d %h %h want=00000 0 0 0 0 0",
                     {mem_ready, axi.awvalid, axi.wvalid, axi.bready, frame_done},
                     status, write_count, last_frame_count, axi.awaddr, axi.wdata);
        end
        aw_delay = 0; w_delay = 0;
        exp_count = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        repeat (10) @(negedge clk);
        checks++;
        if (status !== 32'd0 || got_aw.size() != 0) begin
            errors++;
            $display("FAIL midreset_empty got=%h/%0d want=0/0", status, got_aw.size());
        end
        push_point(32'h0006_0000, 64'h99);
        wait_idle(500);
        exp_count += 1;
        checks++;
        if (got_aw.size() != 1 || write_count !== 19'(exp_count)) begin
            errors++;
            $display("FAIL midreset_recover got=%0d/%0d want=1/%0d",
                     got_aw.size(), write_count, exp_count);
        end else begin
            checks++;
            if (got_aw[0] !== 32'h0006_0000 || got_w[0] !== 64'h99) begin
                errors++;
                $display("FAIL midreset_data got=%h/%h want=00060000/99", got_aw[0], got_w[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_aw_delay();
        test_overflow();
        test_frame();
        test_bresp();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time_limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
